axi_req_index_arbiter: RTL and testbench

//   Front end of the DRAM cache request path. Arbitrates AXI AR and AW

---
 rtl/axi_req_index_arbiter.sv | 110 +++++++++++
 tb/tb_axi_req_index_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_req_index_arbiter.sv
// AXI AR/AW request arbiter: accepts at most one address per cycle, extracts the
// cache set index and pushes {is_write, id, addr} into the request FIFO one cycle later.
module axi_req_index_arbiter #(
  parameter int ADDR_WIDTH   = 64,
  parameter int ID_WIDTH     = 16,
  parameter int INDEX_WIDTH  = 4,
  parameter int OFFSET_WIDTH = 6,
  parameter int ARB_MODE     = 0,
  parameter int STARVE_LIMIT = 4,
  localparam int FIFO_DW     = 1 + ID_WIDTH + ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ID_WIDTH-1:0]    arid_i,
  input  logic [ADDR_WIDTH-1:0]  araddr_i,
  input  logic                   arvalid_i,
  output logic                   arready_o,
  input  logic [ID_WIDTH-1:0]    awid_i,
  input  logic [ADDR_WIDTH-1:0]  awaddr_i,
  input  logic                   awvalid_i,
  output logic                   awready_o,
  output logic [INDEX_WIDTH-1:0] index_o,
  output logic                   index_valid_o,
  input  logic                   fifo_afull_i,
  output logic                   fifo_write_en_o,
  output logic [FIFO_DW-1:0]     fifo_data_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  generate
    if (OFFSET_WIDTH + INDEX_WIDTH > ADDR_WIDTH) begin : g_bad_index
      $error("axi_req_index_arbiter: OFFSET_WIDTH+INDEX_WIDTH exceeds ADDR_WIDTH");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_starve
      $error("axi_req_index_arbiter: STARVE_LIMIT must be at least 1");
    end
  endgenerate

  typedef enum logic {GRANT_RD, GRANT_WR} grant_e;

  grant_e               last_grant;
  logic [SW-1:0]        starve_cnt;
  logic                 gnt_rd;
  logic                 gnt_wr;
  logic                 xfer_rd;
  logic                 xfer_wr;
  logic [ID_WIDTH-1:0]  req_id;
  logic [ADDR_WIDTH-1:0] req_addr;

  always_comb begin
    gnt_rd = 1'b0;
    gnt_wr = 1'b0;
    if (!fifo_afull_i) begin
      if (arvalid_i && awvalid_i) begin
        if (ARB_MODE == 0) begin
          gnt_wr = (last_grant == GRANT_RD);
          gnt_rd = (last_grant == GRANT_WR);
        end else begin
          gnt_wr = (starve_cnt == STARVE_MAX);
          gnt_rd = (starve_cnt != STARVE_MAX);
        end
      end else begin
        gnt_rd = arvalid_i;
        gnt_wr = awvalid_i;
      end
    end
  end

  // Readies are forced low while reset is held, independent of the clock.
  assign arready_o = gnt_rd & rst_n;
  assign awready_o = gnt_wr & rst_n;
  assign xfer_rd   = arvalid_i & arready_o;
  assign xfer_wr   = awvalid_i & awready_o;
  assign req_id    = xfer_wr ? awid_i   : arid_i;
  assign req_addr  = xfer_wr ? awaddr_i : araddr_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GRANT_RD;
      starve_cnt <= '0;
    end else begin
      if (xfer_wr)      last_grant <= GRANT_WR;
      else if (xfer_rd) last_grant <= GRANT_RD;

      if (!awvalid_i || xfer_wr)
        starve_cnt <= '0;
      else if (xfer_rd && starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_write_en_o <= 1'b0;
      index_valid_o   <= 1'b0;
      fifo_data_o     <= '0;
      index_o         <= '0;
    end else begin
      fifo_write_en_o <= xfer_rd | xfer_wr;
      index_valid_o   <= xfer_rd | xfer_wr;
      if (xfer_rd || xfer_wr) begin
        fifo_data_o <= {xfer_wr, req_id, req_addr};
        index_o     <= req_addr[OFFSET_WIDTH+INDEX_WIDTH-1:OFFSET_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_axi_req_index_arbiter.sv
// Randomised self-checking bench: three arbiter configurations share one stimulus
// stream and are compared against a behavioural model of the arbitration rules.
module tb_axi_req_index_arbiter;

  localparam int N = 3;

  logic        clk;
  logic        rst_n;
  logic [15:0] arid;
  logic [63:0] araddr;
  logic        arvalid;
  logic [15:0] awid;
  logic [63:0] awaddr;
  logic        awvalid;
  logic        fifo_afull;

  logic        arready  [N];
  logic        awready  [N];
  logic        idx_vld  [N];
  logic        fwe      [N];
  logic [80:0] fdata    [N];
  logic [7:0]  idx      [N];
  logic [3:0]  idx0, idx1;
  logic [7:0]  idx2;

  int mode   [N] = '{0, 1, 1};
  int limit  [N] = '{4, 4, 2};
  int offw   [N] = '{6, 6, 0};
  int idxw   [N] = '{4, 4, 8};

  // model state
  bit          m_last_wr [N];
  int          m_starve  [N];
  int          m_gnt     [N];
  logic        exp_fwe   [N];
  logic [80:0] exp_data  [N];
  logic [7:0]  exp_idx   [N];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  axi_req_index_arbiter #(.ARB_MODE(0), .STARVE_LIMIT(4)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .arid_i(arid), .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready[0]),
    .awid_i(awid), .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready[0]),
    .index_o(idx0), .index_valid_o(idx_vld[0]), .fifo_afull_i(fifo_afull),
    .fifo_write_en_o(fwe[0]), .fifo_data_o(fdata[0]));

  axi_req_index_arbiter #(.ARB_MODE(1), .STARVE_LIMIT(4)) u_rp (
    .clk(clk), .rst_n(rst_n),
    .arid_i(arid), .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready[1]),
    .awid_i(awid), .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready[1]),
    .index_o(idx1), .index_valid_o(idx_vld[1]), .fifo_afull_i(fifo_afull),
    .fifo_write_en_o(fwe[1]), .fifo_data_o(fdata[1]));

  axi_req_index_arbiter #(.ARB_MODE(1), .STARVE_LIMIT(2), .OFFSET_WIDTH(0), .INDEX_WIDTH(8)) u_o0 (
    .clk(clk), .rst_n(rst_n),
    .arid_i(arid), .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready[2]),
    .awid_i(awid), .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready[2]),
    .index_o(idx2), .index_valid_o(idx_vld[2]), .fifo_afull_i(fifo_afull),
    .fifo_write_en_o(fwe[2]), .fifo_data_o(fdata[2]));

  assign idx[0] = {4'b0, idx0};
  assign idx[1] = {4'b0, idx1};
  assign idx[2] = idx2;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // 0 = no grant, 1 = read, 2 = write
  function automatic int mdl_grant(input int k);
    if (fifo_afull || (!arvalid && !awvalid)) return 0;
    if (arvalid && !awvalid) return 1;
    if (awvalid && !arvalid) return 2;
    if (mode[k] == 0) return m_last_wr[k] ? 1 : 2;
    return (m_starve[k] == limit[k]) ? 2 : 1;
  endfunction

  task automatic mdl_reset();
    for (int k = 0; k < N; k++) begin
      m_last_wr[k] = 1'b0;
      m_starve[k]  = 0;
      exp_fwe[k]   = 1'b0;
      exp_data[k]  = '0;
      exp_idx[k]   = '0;
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int k = 0; k < N; k++) begin
      check({tag, "_fwe"},  fwe[k],     exp_fwe[k]);
      check({tag, "_ivld"}, idx_vld[k], exp_fwe[k]);
      check({tag, "_data"}, fdata[k],   exp_data[k]);
      check({tag, "_idx"},  idx[k],     exp_idx[k]);
    end
  endtask

  // One clock: readies checked mid-cycle, registered outputs checked after the edge.
  task automatic step(input string tag);
    logic [63:0] a;
    @(negedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      m_gnt[k] = mdl_grant(k);
      check({tag, "_arready"}, arready[k], m_gnt[k] == 1);
      check({tag, "_awready"}, awready[k], m_gnt[k] == 2);
      check({tag, "_onehot"},  arready[k] & awready[k], 1'b0);
    end
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      exp_fwe[k] = (m_gnt[k] != 0);
      if (m_gnt[k] != 0) begin
        a            = (m_gnt[k] == 2) ? awaddr : araddr;
        exp_data[k]  = {(m_gnt[k] == 2), (m_gnt[k] == 2) ? awid : arid, a};
        exp_idx[k]   = 8'((a >> offw[k]) & ((64'd1 << idxw[k]) - 1));
        m_last_wr[k] = (m_gnt[k] == 2);
      end
      if (!awvalid || m_gnt[k] == 2) m_starve[k] = 0;
      else if (m_gnt[k] == 1 && m_starve[k] < limit[k]) m_starve[k]++;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic randomize_payload();
    arid   = 16'($urandom);
    awid   = 16'($urandom);
    araddr = {$urandom, $urandom};
    awaddr = {$urandom, $urandom};
  endtask

  initial begin
    rst_n = 1'b0; arvalid = 1'b0; awvalid = 1'b0; fifo_afull = 1'b0;
    arid = '0; awid = '0; araddr = '0; awaddr = '0;
    mdl_reset();
    #12;
    check_outputs("reset");
    for (int k = 0; k < N; k++) check("reset_rdy", {arready[k], awready[k]}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // single read, fixed values
    arvalid = 1'b1; arid = 16'h3; araddr = 64'h1C0;
    step("t1");
    check("t1_data_const", fdata[0], {1'b0, 16'h3, 64'h1C0});
    check("t1_idx_const",  idx[0], 8'h07);
    check("t1_fwe_const",  fwe[0], 1'b1);

    // single write on the zero-offset, 8-bit-index instance
    arvalid = 1'b0; awvalid = 1'b1; awid = 16'h55; awaddr = 64'hABCD;
    step("t6");
    check("t6_idx_const", idx[2], 8'hCD);
    check("t6_msb_const", fdata[2][80], 1'b1);

    // both valid: alternation / read priority with starvation release
    arvalid = 1'b1; awvalid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      randomize_payload();
      step("both");
    end

    // almost-full blocks new grants, then release
    fifo_afull = 1'b1;
    for (int i = 0; i < 3; i++) step("afull");
    check("afull_nopush", fwe[0], 1'b0);
    fifo_afull = 1'b0;
    step("afull_rel");
    check("afull_resume", fwe[0], 1'b1);

    // reset in the cycle after a transfer
    arvalid = 1'b1; awvalid = 1'b0;
    randomize_payload();
    step("pre_rst");
    rst_n = 1'b0;
    #1;
    mdl_reset();
    check_outputs("rst_mid");
    for (int k = 0; k < N; k++) check("rst_mid_rdy", {arready[k], awready[k]}, 2'b00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    arvalid = 1'b0;
    step("post_rst");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      arvalid    = ($urandom_range(0, 3) != 0);
      awvalid    = ($urandom_range(0, 3) != 0);
      fifo_afull = ($urandom_range(0, 7) == 0);
      randomize_payload();
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
